// File: rtl/stream_fork_sched.sv
// stream_fork_sched
//   Dynamic stream fork scheduler. Each input ready/valid transaction is
//   forked to the outputs selected by sel_i. Each selected output handshakes
//   at most once per transaction, and the outputs handshake independently.
//   The input handshakes once every selected output has handshaked.
//   It also provides transaction/drop counters and a synchronous flush that
//   testbench sequencers can use.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   flush_i            abort the in-flight transaction (synchronous)
//   valid_i / ready_o  input stream handshake
//   sel_i  [N_OUP]     output select mask, held stable while stalled
//   valid_o[N_OUP]     per-output valid
//   ready_i[N_OUP]     per-output ready
//   busy_o             some output of the current transaction already handshaked
//   txn_cnt_o [CNT_W]  input handshakes with a non-empty mask (wraps)
//   drop_cnt_o[CNT_W]  input handshakes with an empty mask (wraps)
//   stall_cnt_o[CNT_W] only with STREAM_FORK_SCHED_STALL_CNT_EN: cycles in
//                      which valid_i is stalled, saturating
//
// Optional feature macro: STREAM_FORK_SCHED_STALL_CNT_EN
`timescale 1ns/1ps
module stream_fork_sched #(
    parameter int N_OUP = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [N_OUP-1:0] sel_i,
    output logic [N_OUP-1:0] valid_o,
    input  logic [N_OUP-1:0] ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] txn_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o
`ifdef STREAM_FORK_SCHED_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o
`endif
);

`ifndef SYNTHESIS
    if (N_OUP < 1) begin : g_bad_n_oup
        $fatal(1, "stream_fork_sched: N_OUP must be >= 1");
    end
`endif

    logic [N_OUP-1:0] done_q, done_d;
    logic [N_OUP-1:0] hs, pend;
    logic             in_hs;
    logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        valid_o = {N_OUP{valid_i & ~flush_i}} & sel_i & ~done_q;
        hs      = valid_o & ready_i;
        // Selected outputs that will still be missing after this cycle.
        pend    = sel_i & ~done_q & ~hs;
        ready_o = valid_i & ~flush_i & ~(|pend);
        in_hs   = valid_i & ready_o;
        busy_o  = |done_q;

        done_d = done_q | hs;
        if (flush_i || in_hs) done_d = '0;

        txn_cnt_d  = txn_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (in_hs) begin
            if (|sel_i) txn_cnt_d  = txn_cnt_q + CNT_W'(1);
            else        drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q     <= '0;
            txn_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            done_q     <= done_d;
            txn_cnt_q  <= txn_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign txn_cnt_o  = txn_cnt_q;
    assign drop_cnt_o = drop_cnt_q;

`ifdef STREAM_FORK_SCHED_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_i && !ready_o && !flush_i && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
    // The upstream may not change the mask of a stalled transaction.
    // A flush releases that obligation.
    sel_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_i && !ready_o && !flush_i) |=> (!valid_i || sel_i == $past(sel_i)))
        else $error("stream_fork_sched: sel_i changed while stalled");
`endif

endmodule

// File: tb/tb_stream_fork_sched.sv
`timescale 1ns/1ps
module tb_stream_fork_sched;
    localparam int N = 3;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni, flush_i, valid_i, ready_o, busy_o;
    logic [N-1:0]  sel_i, valid_o, ready_i;
    logic [CW-1:0] txn_cnt_o, drop_cnt_o;
`ifdef STREAM_FORK_SCHED_STALL_CNT_EN
    logic [CW-1:0] stall_cnt_o;
`endif

    stream_fork_sched #(.N_OUP(N), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o), .sel_i(sel_i),
        .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o),
        .txn_cnt_o(txn_cnt_o), .drop_cnt_o(drop_cnt_o)
`ifdef STREAM_FORK_SCHED_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Reference model: the set of outputs already served in the current
    // transaction, plus plain integer counters.
    bit     served [N];
    int     m_txn, m_drop, m_stall;
    logic   m_ready;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) served[i] = 1'b0;
        m_txn = 0; m_drop = 0; m_stall = 0;
    endtask

    // Apply one cycle of stimulus, compare against the model, clock it.
    task automatic step(input logic v, input logic f, input logic [N-1:0] s,
                        input logic [N-1:0] r);
        logic [N-1:0] ev;
        bit all_ok, any_served;
        valid_i = v; flush_i = f; sel_i = s; ready_i = r;
        #1;
        all_ok = 1; any_served = 0;
        for (int i = 0; i < N; i++) begin
            ev[i] = v && s[i] && !served[i] && !f;
            if (s[i] && !served[i] && !r[i]) all_ok = 0;
            if (served[i]) any_served = 1;
        end
        m_ready = v && !f && all_ok;
        chk("valid_o", int'(valid_o), int'(ev));
        chk("ready_o", int'(ready_o), int'(m_ready));
        chk("busy_o", int'(busy_o), int'(any_served));
        chk("txn_cnt", int'(txn_cnt_o), m_txn);
        chk("drop_cnt", int'(drop_cnt_o), m_drop);
`ifdef STREAM_FORK_SCHED_STALL_CNT_EN
        chk("stall_cnt", int'(stall_cnt_o), m_stall);
`endif
        @(posedge clk_i);
        if (v && !m_ready && !f && m_stall < 15) m_stall++;
        if (f) begin
            for (int i = 0; i < N; i++) served[i] = 1'b0;
        end else if (m_ready) begin
            for (int i = 0; i < N; i++) served[i] = 1'b0;
            if (s != 0) m_txn = (m_txn + 1) % 16;
            else        m_drop = (m_drop + 1) % 16;
        end else begin
            for (int i = 0; i < N; i++) if (ev[i] && r[i]) served[i] = 1'b1;
        end
        @(negedge clk_i);
    endtask

    typedef struct {
        logic v, f;
        logic [N-1:0] s, r;
        logic [N-1:0] evo;
        logic er, eb;
        int etxn, edrop;
    } vec_t;

    vec_t tbl[9];
    bit   hold;
    logic [N-1:0] hs_sel;
    logic hv, hf;

    initial begin
        tbl[0] = '{1,0,3'b111,3'b111, 3'b111,1,0, 0,0};  // full single-cycle fork
        tbl[1] = '{1,0,3'b101,3'b001, 3'b101,0,0, 1,0};  // partial: out0 served
        tbl[2] = '{1,0,3'b101,3'b100, 3'b100,1,1, 1,0};  // out2 completes
        tbl[3] = '{1,0,3'b000,3'b000, 3'b000,1,0, 2,0};  // empty mask drop
        tbl[4] = '{1,0,3'b011,3'b001, 3'b011,0,0, 2,1};  // out0 served
        tbl[5] = '{1,1,3'b011,3'b000, 3'b000,0,1, 2,1};  // flush cycle
        tbl[6] = '{1,0,3'b011,3'b000, 3'b011,0,0, 2,1};  // re-presented, idle
        tbl[7] = '{1,0,3'b011,3'b011, 3'b011,1,0, 2,1};
        tbl[8] = '{0,0,3'b000,3'b000, 3'b000,0,0, 3,1};

        rst_ni = 1'b0; valid_i = 0; flush_i = 0; sel_i = '0; ready_i = '0;
        model_reset();
        repeat (2) @(negedge clk_i);
        chk("rst_ready_o", int'(ready_o), 0);
        chk("rst_valid_o", int'(valid_o), 0);
        chk("rst_busy_o", int'(busy_o), 0);
        chk("rst_txn", int'(txn_cnt_o), 0);
        chk("rst_drop", int'(drop_cnt_o), 0);
        rst_ni = 1'b1;

        // Directed table
        for (int k = 0; k < 9; k++) begin
            valid_i = tbl[k].v; flush_i = tbl[k].f; sel_i = tbl[k].s; ready_i = tbl[k].r;
            #1;
            chk("tbl_valid_o", int'(valid_o), int'(tbl[k].evo));
            chk("tbl_ready_o", int'(ready_o), int'(tbl[k].er));
            chk("tbl_busy_o", int'(busy_o), int'(tbl[k].eb));
            chk("tbl_txn", int'(txn_cnt_o), tbl[k].etxn);
            chk("tbl_drop", int'(drop_cnt_o), tbl[k].edrop);
            step(tbl[k].v, tbl[k].f, tbl[k].s, tbl[k].r);
        end

        // Asynchronous reset in the middle of a partial transaction
        step(1, 0, 3'b011, 3'b001);
        chk("partial_busy", int'(busy_o), 1);
        #2;
        rst_ni = 1'b0; valid_i = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy_o), 0);
        chk("async_rst_txn", int'(txn_cnt_o), 0);
        chk("async_rst_valid_o", int'(valid_o), 0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Counter wrap: 17 back-to-back full handshakes
        for (int k = 0; k < 17; k++) step(1, 0, 3'b111, 3'b111);
        chk("txn_wrap", int'(txn_cnt_o), 1);

`ifdef STREAM_FORK_SCHED_STALL_CNT_EN
        rst_ni = 1'b0; valid_i = 1'b0; model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 5; k++) step(1, 0, 3'b010, 3'b000);
        chk("stall_5", int'(stall_cnt_o), 5);
        #2;
        rst_ni = 1'b0; valid_i = 1'b0;
        #1;
        chk("stall_async_rst", int'(stall_cnt_o), 0);
        chk("stall_rst_valid_o", int'(valid_o), 0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
`endif

        // Randomized traffic against the model, obeying the stability rule
        hold = 0; hs_sel = '0;
        for (int k = 0; k < 1500; k++) begin
            if (!hold) begin
                hv = ($urandom_range(0, 3) != 0);
                hs_sel = N'($urandom);
            end else begin
                hv = 1'b1;
            end
            hf = ($urandom_range(0, 15) == 0);
            step(hv, hf, hs_sel, N'($urandom));
            hold = hv && !m_ready && !hf;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
